param_stack: RTL and testbench

- Parametrised data stack for the stack-machine datapath, the next generation of the 16-bit TOS/NOS stack.
- TOS and NOS are registers. The remaining DEPTH-2 entries live in a spill array.
- Adds configurable width and depth, an occupancy count, full/empty status, a SWAP operation, and sticky overflow/underflow error flags.
- Sits between the ALU (TOS/NOS operands) and the control unit (push/pop/write strobes).

---
 rtl/stack_pkg.sv | 14 +
 rtl/param_stack_if.sv | 34 +++
 rtl/stack_spill_mem.sv | 25 ++
 rtl/param_stack.sv | 115 +++++++++++
 tb/tb_param_stack.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared constants and operation encoding for the parametrised data stack.
package stack_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 16;

  typedef enum logic [2:0] {NOP, PUSH, POP, SWAP, REPL} stack_op_t;

  // Address width that never collapses to zero bits for tiny arrays
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Control/data bundle between the control unit / ALU (master) and the stack (slave).
interface param_stack_if
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);
  logic [WIDTH-1:0] top_in;
  logic [WIDTH-1:0] next_in;
  logic             push;
  logic             pop;
  logic             swap;
  logic             w_tos;
  logic             w_next;
  logic             clr_err;
  logic [WIDTH-1:0] top_out;
  logic [WIDTH-1:0] next_out;
  logic [CNT_W-1:0] depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output top_in, next_in, push, pop, swap, w_tos, w_next, clr_err,
    input  top_out, next_out, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  top_in, next_in, push, pop, swap, w_tos, w_next, clr_err,
    output top_out, next_out, depth, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_spill_mem.sv
// Register-file backing store for stack entries below NOS.
// Synchronous write, combinational read; contents are not reset.
module stack_spill_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 14,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < N) rdata = mem[raddr];
  end
endmodule

// File: rtl/param_stack.sv
// Parametrised data stack: TOS/NOS registers over a DEPTH-2 spill array,
// with occupancy count, full/empty status and sticky overflow/underflow flags.
module param_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  param_stack_if.slave bus
);
  localparam int unsigned SPILL_N = DEPTH - 2;
  localparam int unsigned AW      = addr_w(SPILL_N);

  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             ovf_q, unf_q;
  logic             ovf_set, unf_set;
  logic             is_full, is_empty;
  logic             spill_we;
  logic [AW-1:0]    spill_waddr, spill_raddr;
  logic [WIDTH-1:0] spill_rdata;
  stack_op_t        op;

  assign is_full     = (depth_q == CNT_W'(DEPTH));
  assign is_empty    = (depth_q == '0);
  assign spill_waddr = AW'(depth_q - CNT_W'(2));
  assign spill_raddr = AW'(depth_q - CNT_W'(3));

  stack_spill_mem #(
    .WIDTH (WIDTH),
    .N     (SPILL_N),
    .AW    (AW)
  ) u_spill (
    .clk   (clk),
    .we    (spill_we),
    .waddr (spill_waddr),
    .wdata (next_q),
    .raddr (spill_raddr),
    .rdata (spill_rdata)
  );

  // push+pop together is a replace; swap only counts when neither shift is requested
  always_comb begin
    op = NOP;
    if (bus.push && bus.pop) op = REPL;
    else if (bus.push)       op = PUSH;
    else if (bus.pop)        op = POP;
    else if (bus.swap)       op = SWAP;
  end

  always_comb begin
    top_d    = top_q;
    next_d   = next_q;
    depth_d  = depth_q;
    spill_we = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    unique case (op)
      PUSH: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          next_d   = top_q;
          spill_we = (depth_q >= CNT_W'(2));
          depth_d  = depth_q + CNT_W'(1);
        end
      end
      POP: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          top_d   = next_q;
          next_d  = (depth_q >= CNT_W'(3)) ? spill_rdata : '0;
          depth_d = depth_q - CNT_W'(1);
        end
      end
      SWAP: begin
        top_d  = next_q;
        next_d = top_q;
      end
      default: ;
    endcase
    // Direct writes take precedence over whatever the shift/swap produced
    if (bus.w_tos)  top_d  = bus.top_in;
    if (bus.w_next) next_d = bus.next_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q   <= '0;
      next_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      next_q  <= next_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_set | (ovf_q & ~bus.clr_err);
      unf_q   <= unf_set | (unf_q & ~bus.clr_err);
    end
  end

  assign bus.top_out   = top_q;
  assign bus.next_out  = next_q;
  assign bus.depth     = depth_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: the driver queues hand-computed expected
// state per cycle, the monitor compares after each clock edge or reset assertion.
module tb_param_stack;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;

  localparam logic [5:0] C_P = 6'b000001;
  localparam logic [5:0] C_O = 6'b000010;
  localparam logic [5:0] C_S = 6'b000100;
  localparam logic [5:0] C_T = 6'b001000;
  localparam logic [5:0] C_N = 6'b010000;
  localparam logic [5:0] C_C = 6'b100000;

  typedef struct {
    string       tag;
    logic [15:0] top;
    logic [15:0] nxt;
    int unsigned dep;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h (t=%0t)", tag, fld, act, exp, $time);
    end
  endfunction

  // Monitor: outputs are registered, so sample 1ns after each edge / reset fall
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "top_out",   32'(bus.top_out),   32'(e.top));
        chk(e.tag, "next_out",  32'(bus.next_out),  32'(e.nxt));
        chk(e.tag, "depth",     32'(bus.depth),     e.dep);
        chk(e.tag, "empty",     32'(bus.empty),     32'(e.dep == 0));
        chk(e.tag, "full",      32'(bus.full),      32'(e.dep == DEPTH));
        chk(e.tag, "overflow",  32'(bus.overflow),  32'(e.ovf));
        chk(e.tag, "underflow", 32'(bus.underflow), 32'(e.unf));
      end
    end
  end

  task automatic drive(input logic [5:0] c, input logic [15:0] ti, input logic [15:0] ni);
    bus.push    = c[0];
    bus.pop     = c[1];
    bus.swap    = c[2];
    bus.w_tos   = c[3];
    bus.w_next  = c[4];
    bus.clr_err = c[5];
    bus.top_in  = ti;
    bus.next_in = ni;
  endtask

  // One cycle: apply strobes, queue the state expected after the edge
  task automatic step(input logic [5:0] c, input logic [15:0] ti, input logic [15:0] ni,
                      input string tag, input logic [15:0] et, input logic [15:0] en,
                      input int unsigned ed, input logic eo, input logic eu);
    exp_t e;
    drive(c, ti, ni);
    e.tag = tag; e.top = et; e.nxt = en; e.dep = ed; e.ovf = eo; e.unf = eu;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    exp_t e;
    drive('0, '0, '0);
    #12 rst = 1'b1;
    @(posedge clk);
    #2;

    step('0, '0, '0, "reset_idle", 16'h0000, 16'h0000, 0, 0, 0);

    step(C_T,       16'hCCCC, '0, "w_tos",   16'hCCCC, 16'h0000, 0, 0, 0);
    step(C_P | C_T, 16'h3333, '0, "push1",   16'h3333, 16'hCCCC, 1, 0, 0);
    step(C_P | C_T, 16'h39A5, '0, "push2",   16'h39A5, 16'h3333, 2, 0, 0);
    step(C_P | C_T, 16'hB38F, '0, "push3",   16'hB38F, 16'h39A5, 3, 0, 0);
    step(C_O, '0, '0, "pop1",  16'h39A5, 16'h3333, 2, 0, 0);
    step(C_O, '0, '0, "pop2",  16'h3333, 16'h0000, 1, 0, 0);
    step(C_O, '0, '0, "pop3",  16'h0000, 16'h0000, 0, 0, 0);
    step(C_O, '0, '0, "pop_empty", 16'h0000, 16'h0000, 0, 0, 1);

    step(C_O | C_C, '0, '0, "clr_vs_set", 16'h0000, 16'h0000, 0, 0, 1);
    step(C_C,       '0, '0, "clr_unf",    16'h0000, 16'h0000, 0, 0, 0);

    for (int v = 1; v <= 16; v++)
      step(C_P | C_T, 16'(v), '0, "fill", 16'(v), 16'(v - 1), v, 0, 0);
    step(C_P | C_T, 16'd17, '0, "push_full", 16'd17, 16'd15, 16, 1, 0);
    for (int k = 1; k <= 15; k++)
      step(C_O, '0, '0, "drain", 16'(16 - k), 16'(15 - k), 16 - k, 1, 0);
    step(C_C, '0, '0, "clr_ovf", 16'd1, 16'd0, 1, 0, 0);

    step(C_T | C_N, 16'hAAAA, 16'h5555, "load_tn", 16'hAAAA, 16'h5555, 1, 0, 0);
    step(C_S,       '0, '0, "swap",      16'h5555, 16'hAAAA, 1, 0, 0);
    step(C_S | C_P, '0, '0, "swap_push", 16'h5555, 16'h5555, 2, 0, 0);
    step(C_P | C_T, 16'h0777, '0, "push_a", 16'h0777, 16'h5555, 3, 0, 0);
    step(C_P | C_T, 16'h0888, '0, "push_b", 16'h0888, 16'h0777, 4, 0, 0);
    step(C_P | C_O | C_T, 16'h1234, '0, "replace", 16'h1234, 16'h0777, 4, 0, 0);
    step(C_O,       '0, '0, "pop_spill", 16'h0777, 16'h5555, 3, 0, 0);
    step(C_O | C_N, '0, 16'h0ABC, "pop_wnext", 16'h5555, 16'h0ABC, 2, 0, 0);

    // Asynchronous reset between edges: monitor samples 1ns after the fall
    drive('0, '0, '0);
    e.tag = "async_rst"; e.top = '0; e.nxt = '0; e.dep = 0; e.ovf = 0; e.unf = 0;
    sb.push_back(e);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step('0, '0, '0, "post_rst", 16'h0000, 16'h0000, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard", "drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
